// File: rtl/color_strength_accumulator.sv
// Frame-level accumulator for per-pixel channel flags and strength.
// Counts red/green/blue hits and sums strength over PIXEL_NUM accepted
// pixels, then classifies the frame by its dominant channel.
module color_strength_accumulator #(
   parameter int PIXEL_NUM = 1024,
   parameter int CNT_W     = 16,
   parameter int SUM_W     = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic             Radd_en,
   input  logic             Gadd_en,
   input  logic             Badd_en,
   input  logic [7:0]       strength_input,
   output logic             busy,
   output logic             done,
   output logic [1:0]       class_out,
   output logic [CNT_W-1:0] r_cnt,
   output logic [CNT_W-1:0] g_cnt,
   output logic [CNT_W-1:0] b_cnt,
   output logic [SUM_W-1:0] total_strength
);

   typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, DONE} state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] pix_cnt;
   logic             accept;
   logic             last_pix;

   assign accept   = pix_valid & pix_ready;
   assign last_pix = accept && (pix_cnt == CNT_W'(PIXEL_NUM - 1));

   // Add an 8-bit strength to the accumulator, clamping at all-ones.
   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] acc,
                                                input logic [7:0]       s);
      logic [SUM_W:0] ext;
      ext = {1'b0, acc} + (SUM_W + 1)'(s);
      if (ext[SUM_W])
         return '1;
      return ext[SUM_W-1:0];
   endfunction

   // Dominant channel with R > G > B tie priority; 0 when nothing was hit.
   function automatic logic [1:0] classify(input logic [CNT_W-1:0] r,
                                           input logic [CNT_W-1:0] g,
                                           input logic [CNT_W-1:0] b);
      if (r == '0 && g == '0 && b == '0)
         return 2'd0;
      if (r >= g && r >= b)
         return 2'd1;
      if (g >= b)
         return 2'd2;
      return 2'd3;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ACCUM;
         ACCUM:   if (last_pix) next_state = DECIDE;
         DECIDE:  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Registered handshake and status outputs, derived from the upcoming state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         pix_ready <= (next_state == ACCUM);
         busy      <= (next_state != IDLE);
         done      <= (next_state == DONE);
      end
   end

   // Counters, strength accumulator and classification result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt        <= '0;
         r_cnt          <= '0;
         g_cnt          <= '0;
         b_cnt          <= '0;
         total_strength <= '0;
         class_out      <= 2'd0;
      end else begin
         if (state == IDLE && start) begin
            pix_cnt        <= '0;
            r_cnt          <= '0;
            g_cnt          <= '0;
            b_cnt          <= '0;
            total_strength <= '0;
            class_out      <= 2'd0;
         end else if (state == ACCUM && accept) begin
            pix_cnt        <= pix_cnt + 1'b1;
            total_strength <= sat_add(total_strength, strength_input);
            if (Radd_en) r_cnt <= r_cnt + 1'b1;
            if (Gadd_en) g_cnt <= g_cnt + 1'b1;
            if (Badd_en) b_cnt <= b_cnt + 1'b1;
         end else if (state == DECIDE) begin
            class_out <= classify(r_cnt, g_cnt, b_cnt);
         end
      end
   end

endmodule

// File: tb/tb_color_strength_accumulator.sv
// Directed bench for color_strength_accumulator with a result scoreboard.
// Two instances share stimulus: SUM_W=24 and SUM_W=8 (saturation).
module tb_color_strength_accumulator;

   localparam int PN = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          pix_valid = 1'b0;
   logic          Radd_en = 1'b0;
   logic          Gadd_en = 1'b0;
   logic          Badd_en = 1'b0;
   logic [7:0]    strength_input = 8'd0;

   logic          pix_ready, busy, done;
   logic [1:0]    class_out;
   logic [CW-1:0] r_cnt, g_cnt, b_cnt;
   logic [23:0]   total_strength;

   logic          s_pix_ready, s_busy, s_done;
   logic [1:0]    s_class_out;
   logic [CW-1:0] s_r_cnt, s_g_cnt, s_b_cnt;
   logic [7:0]    s_total_strength;

   color_strength_accumulator #(.PIXEL_NUM(PN), .CNT_W(CW), .SUM_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .Radd_en(Radd_en), .Gadd_en(Gadd_en),
      .Badd_en(Badd_en), .strength_input(strength_input), .busy(busy),
      .done(done), .class_out(class_out), .r_cnt(r_cnt), .g_cnt(g_cnt),
      .b_cnt(b_cnt), .total_strength(total_strength));

   color_strength_accumulator #(.PIXEL_NUM(PN), .CNT_W(CW), .SUM_W(8)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
      .pix_ready(s_pix_ready), .Radd_en(Radd_en), .Gadd_en(Gadd_en),
      .Badd_en(Badd_en), .strength_input(strength_input), .busy(s_busy),
      .done(s_done), .class_out(s_class_out), .r_cnt(s_r_cnt), .g_cnt(s_g_cnt),
      .b_cnt(s_b_cnt), .total_strength(s_total_strength));

   always #5 clk = ~clk;

   typedef struct {
      int r;
      int g;
      int b;
      int tot;
      int tot8;
      int cls;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_r, m_g, m_b, m_tot;
   int   done_pulses = 0;
   int   waited;
   int   pulses_before;

   always @(posedge clk) if (done) done_pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_class(input int r, input int g, input int b);
      if (r == 0 && g == 0 && b == 0) return 0;
      if (r >= g && r >= b) return 1;
      if (g >= b) return 2;
      return 3;
   endfunction

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      m_r = 0; m_g = 0; m_b = 0; m_tot = 0;
   endtask

   // One valid pixel; f = {R,G,B}.
   task automatic px(input logic [2:0] f, input int s);
      pix_valid = 1'b1;
      {Radd_en, Gadd_en, Badd_en} = f;
      strength_input = s[7:0];
      tick();
      m_r += int'(f[2]); m_g += int'(f[1]); m_b += int'(f[0]); m_tot += s;
      pix_valid = 1'b0;
      {Radd_en, Gadd_en, Badd_en} = 3'b000;
      strength_input = 8'd0;
   endtask

   // Invalid cycle with junk on the data lines; optional stray start.
   task automatic gap(input logic st);
      pix_valid = 1'b0;
      start = st;
      {Radd_en, Gadd_en, Badd_en} = 3'b111;
      strength_input = 8'd99;
      tick();
      start = 1'b0;
      {Radd_en, Gadd_en, Badd_en} = 3'b000;
      strength_input = 8'd0;
   endtask

   task automatic push_expected();
      exp_t e;
      e.r = m_r; e.g = m_g; e.b = m_b; e.tot = m_tot;
      e.tot8 = (m_tot > 255) ? 255 : m_tot;
      e.cls = model_class(m_r, m_g, m_b);
      sb.push_back(e);
   endtask

   task automatic wait_done(input string tag, output int n);
      exp_t e;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      if (done && sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_r"}, 32'(r_cnt), 32'(e.r));
         check({tag, "_g"}, 32'(g_cnt), 32'(e.g));
         check({tag, "_b"}, 32'(b_cnt), 32'(e.b));
         check({tag, "_tot"}, 32'(total_strength), 32'(e.tot));
         check({tag, "_cls"}, 32'(class_out), 32'(e.cls));
         check({tag, "_tot8"}, 32'(s_total_strength), 32'(e.tot8));
         check({tag, "_cls8"}, 32'(s_class_out), 32'(e.cls));
         check({tag, "_done8"}, 32'(s_done), 32'd1);
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_ready"}, 32'(pix_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_cls"}, 32'(class_out), 32'd0);
      check({tag, "_r"}, 32'(r_cnt), 32'd0);
      check({tag, "_g"}, 32'(g_cnt), 32'd0);
      check({tag, "_b"}, 32'(b_cnt), 32'd0);
      check({tag, "_tot"}, 32'(total_strength), 32'd0);
      check({tag, "_tot8"}, 32'(s_total_strength), 32'd0);
   endtask

   initial begin
      // Reset, then asynchronous reset mid-cycle while a frame is running.
      tick();
      tick();
      check_cleared("por");
      rst_n = 1'b1;
      start = 1'b1;
      pix_valid = 1'b1;
      Radd_en = 1'b1;
      strength_input = 8'd33;
      tick();
      tick();
      tick();
      check("pre_rst_r_nonzero", 32'(r_cnt != '0), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_cleared("async_rst");
      start = 1'b0;
      pix_valid = 1'b0;
      Radd_en = 1'b0;
      strength_input = 8'd0;
      tick();
      rst_n = 1'b1;
      tick();

      // Frame A: basic accumulation and latency.
      start_frame();
      check("a_ready_after_start", 32'(pix_ready), 32'd1);
      check("a_busy_after_start", 32'(busy), 32'd1);
      px(3'b100, 10);
      px(3'b100, 20);
      px(3'b010, 30);
      px(3'b001, 40);
      push_expected();
      check("a_ready_low_t1", 32'(pix_ready), 32'd0);
      check("a_done_low_t1", 32'(done), 32'd0);
      check("a_busy_t1", 32'(busy), 32'd1);
      tick();
      wait_done("a", waited);
      check("a_done_latency", 32'(waited), 32'd0);
      tick();
      check("a_done_one_cycle", 32'(done), 32'd0);
      check("a_busy_low_t3", 32'(busy), 32'd0);
      tick();
      tick();
      check("a_hold_r", 32'(r_cnt), 32'd2);
      check("a_hold_cls", 32'(class_out), 32'd1);

      // Frame B: tie between G and B, multi-flag and no-flag pixels.
      start_frame();
      check("b_cleared_r", 32'(r_cnt), 32'd0);
      check("b_cleared_cls", 32'(class_out), 32'd0);
      px(3'b011, 5);
      px(3'b010, 5);
      px(3'b001, 5);
      px(3'b000, 5);
      push_expected();
      wait_done("b", waited);
      tick();

      // Frame C: no flags at all.
      pulses_before = done_pulses;
      start_frame();
      for (int i = 0; i < 4; i++) px(3'b000, 7);
      push_expected();
      wait_done("c", waited);
      for (int i = 0; i < 4; i++) tick();
      check("c_done_pulses", 32'(done_pulses - pulses_before), 32'd1);

      // Frame D: valid gaps and a stray start during accumulation.
      pulses_before = done_pulses;
      start_frame();
      px(3'b100, 1);
      gap(1'b0);
      gap(1'b1);
      px(3'b010, 2);
      gap(1'b0);
      px(3'b010, 3);
      px(3'b001, 4);
      push_expected();
      wait_done("d", waited);
      for (int i = 0; i < 4; i++) tick();
      check("d_done_pulses", 32'(done_pulses - pulses_before), 32'd1);
      check("d_idle_busy", 32'(busy), 32'd0);

      // Frame E: reset after two pixels, then a fresh full frame.
      pulses_before = done_pulses;
      start_frame();
      px(3'b100, 200);
      px(3'b100, 200);
      #2 rst_n = 1'b0;
      #1 check_cleared("midframe_rst");
      tick();
      rst_n = 1'b1;
      tick();
      check("e_no_done_after_rst", 32'(done_pulses - pulses_before), 32'd0);
      start_frame();
      px(3'b001, 50);
      px(3'b001, 60);
      px(3'b100, 70);
      px(3'b010, 80);
      push_expected();
      wait_done("e", waited);
      tick();

      // Frame F: saturation on the 8-bit accumulator.
      start_frame();
      for (int i = 0; i < 4; i++) px(3'b100, 255);
      push_expected();
      wait_done("f", waited);
      check("f_sat_r", 32'(s_r_cnt), 32'd4);
      check("f_sat_tot", 32'(s_total_strength), 32'd255);
      tick();

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/color_strength_accumulator.md
Name: color_strength_accumulator

Overview:
- Downstream consumer of the per-pixel comparator stage.
- Takes that stage's per-pixel channel-enable flags (Radd_en/Gadd_en/Badd_en) and 8-bit strength_input over one frame of PIXEL_NUM pixels.
- Accumulates per-channel hit counts and total strength, then classifies the frame by dominant channel.
- Results feed the image-sorting decision logic; one frame is processed per start pulse.

Parameters:
- PIXEL_NUM, 1024, pixels per frame (>=1).
- CNT_W, 16, width of per-channel and pixel counters; must satisfy 2^CNT_W > PIXEL_NUM.
- SUM_W, 24, width of the total-strength accumulator (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin new frame; honoured only in IDLE.
- pix_valid  in  1  upstream pixel result valid.
- pix_ready  out  1  block accepts pixel this cycle.
- Radd_en  in  1  red channel flag for current pixel.
- Gadd_en  in  1  green channel flag for current pixel.
- Badd_en  in  1  blue channel flag for current pixel.
- strength_input  in  8  strength of current pixel, unsigned.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when results are valid.
- class_out  out  2  0 = none, 1 = red, 2 = green, 3 = blue.
- r_cnt  out  CNT_W  accepted pixels with Radd_en=1.
- g_cnt  out  CNT_W  accepted pixels with Gadd_en=1.
- b_cnt  out  CNT_W  accepted pixels with Badd_en=1.
- total_strength  out  SUM_W  saturating sum of strength_input.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs and internal counters 0; pix_ready=0, busy=0, done=0, class_out=0.
- States: IDLE, ACCUM, DECIDE, DONE. All outputs are registered.
- IDLE:
  - pix_ready=0; results from the previous frame hold.
  - start=1 at a clock edge clears r_cnt, g_cnt, b_cnt, total_strength, class_out and the pixel counter, then enters ACCUM.
- ACCUM:
  - pix_ready=1.
  - Accept = pix_valid & pix_ready.
  - On accept: each asserted flag increments its own counter independently. Multiple flags in one pixel increment multiple counters; no flags is legal and increments none.
  - On accept: total_strength += strength_input, saturating at all-ones. Once saturated it stays saturated.
  - On accept: pixel counter +1.
  - pix_valid=0 cycles are idle; nothing changes.
  - start is ignored.
  - The accept that brings the pixel counter to PIXEL_NUM moves the FSM to DECIDE.
- DECIDE (1 cycle):
  - pix_ready=0.
  - class_out is the channel with the largest count.
  - Tie priority is R > G > B.
  - If all three counts are 0, class_out=0.
  - class_out is registered on exit.
- DONE (1 cycle):
  - done=1 for exactly this cycle, then IDLE.
  - start during DONE is ignored.
- Latency and timing:
  - Last pixel accepted at edge T: pix_ready=0 from T+1, done=1 at T+2, busy=0 from T+3.
  - Minimum frame time is PIXEL_NUM+2 cycles.
- Result persistence:
  - r_cnt, g_cnt, b_cnt and total_strength update live during ACCUM.
  - All results are final and stable from done until the next accepted start.
- Counter overflow cannot occur given the CNT_W constraint; no wrap logic on the channel counters.
- Reset mid-frame: immediate clear to reset values; partial frame discarded. A new start after reset release processes a full frame normally.
- start held high: only one frame per IDLE entry. A start held across DONE begins a new frame on the first IDLE cycle.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with inputs toggling -> all outputs 0 immediately (async), state IDLE, pix_ready=0.
- PIXEL_NUM=4, SUM_W=24. Pixels {R,10},{R,20},{G,30},{B,40}, valid every cycle -> r_cnt=2, g_cnt=1, b_cnt=1, total_strength=100, class_out=1. done pulses exactly 2 cycles after the 4th accept; pix_ready=0 the cycle after the 4th accept.
- Tie and multi-flag: pixels {G+B,5},{G,5},{B,5},{none,5} -> g_cnt=2, b_cnt=2, r_cnt=0, total=20, class_out=2 (G beats B).
- All flags 0 for 4 pixels, strength 7 each -> all counts 0, total_strength=28, class_out=0, done pulses once.
- Handshake: pix_valid gaps (1,0,0,1,0,1,1) plus a start pulse during ACCUM -> only 4 valid pixels counted; start ignored; done fires once. Then rst_n=0 after the 2nd pixel of the next frame -> outputs cleared; fresh start yields correct 4-pixel result.
- Saturation: SUM_W=8, four pixels {R,255} -> total_strength=255 (not wrapped), r_cnt=4, class_out=1.
